// File: rtl/nibble_serial_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nibble_serial_addsub_seq                                          |
// | Brief   : Wide add/subtract built one nibble per clock on an external        |
// |           4-bit adder/subtractor. Optional result clamp on signed overflow   |
// |           via NIBBLE_SERIAL_SATURATE_EN.                                      |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module nibble_serial_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 sub,
  output logic [3:0]           fa_A,
  output logic [3:0]           fa_B,
  output logic                 fa_Cin,
  input  logic [3:0]           fa_Sum,
  input  logic                 fa_Cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int c_W     = 4 * NIBBLES;
  localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_W-1:0]     r_a;
  logic [c_W-1:0]     r_b;
  logic               r_sub;
  logic               r_carry;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_W-1:0]     r_result;
  logic               r_carry_out;
  logic               r_overflow;

  logic               w_last;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [c_W-1:0]     w_result_raw;
  logic [c_W-1:0]     w_result_nxt;
  logic               w_ovf;

  assign w_last  = (r_idx == c_LAST_IDX);
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  // Result as it will look once the current nibble lands; overflow is only
  // meaningful on the last nibble, which is the only time it is registered.
  always_comb begin
    w_result_raw = r_result;
    w_result_raw[{r_idx, 2'b00} +: 4] = fa_Sum;
    w_ovf = (r_a[c_W-1] == (r_b[c_W-1] ^ r_sub)) &&
            (w_result_raw[c_W-1] != r_a[c_W-1]);
    w_result_nxt = w_result_raw;
`ifdef NIBBLE_SERIAL_SATURATE_EN
    if (w_last && w_ovf)
      w_result_nxt = r_a[c_W-1] ? {1'b1, {(c_W-1){1'b0}}} : {1'b0, {(c_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_result <= w_result_nxt;
          r_carry  <= fa_Cout;
          r_idx    <= r_idx + 1'b1;
          if (w_last) begin
            r_carry_out <= fa_Cout;
            r_overflow  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // The adder XORs fa_B with its own Cin, so pre-inverting by sub^carry
  // leaves an effective B of b_nib^sub on every nibble.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    fa_A        = 4'h0;
    fa_B        = 4'h0;
    fa_Cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        fa_A   = w_a_nib;
        fa_B   = w_b_nib ^ {4{r_sub ^ r_carry}};
        fa_Cin = r_carry;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_seq.sv
`default_nettype none
// Bench for nibble_serial_addsub_seq: 16-bit and 4-bit instances, each driving
// a behavioural 4-bit adder/subtractor, checked against a plain-arithmetic model.
module tb_nibble_serial_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, sub, out_ready, in_ready, out_valid, carry_out, overflow;
  logic [15:0] op_a, op_b, result;
  logic [3:0]  fa_A, fa_B, fa_Sum;
  logic        fa_Cin, fa_Cout;

  logic        in_valid1, sub1, out_ready1, in_ready1, out_valid1, carry_out1, overflow1;
  logic [3:0]  op_a1, op_b1, result1;
  logic [3:0]  fa_A1, fa_B1, fa_Sum1;
  logic        fa_Cin1, fa_Cout1;

  int n_total = 0;
  int n_bad   = 0;

  // External adder: B is XORed with Cin internally.
  assign {fa_Cout, fa_Sum}   = 5'(fa_A)  + 5'(fa_B  ^ {4{fa_Cin}})  + 5'(fa_Cin);
  assign {fa_Cout1, fa_Sum1} = 5'(fa_A1) + 5'(fa_B1 ^ {4{fa_Cin1}}) + 5'(fa_Cin1);

  nibble_serial_addsub_seq #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .fa_A(fa_A), .fa_B(fa_B), .fa_Cin(fa_Cin), .fa_Sum(fa_Sum), .fa_Cout(fa_Cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  nibble_serial_addsub_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .sub(sub1),
    .fa_A(fa_A1), .fa_B(fa_B1), .fa_Cin(fa_Cin1), .fa_Sum(fa_Sum1), .fa_Cout(fa_Cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .carry_out(carry_out1), .overflow(overflow1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: W-bit add/sub from integer arithmetic.
  function automatic void ref_model(input int w, input longint a, input longint b, input bit s,
                                    output longint r, output bit c, output bit v);
    longint full, half, sa, sb, exact;
    full = longint'(1) << w;
    half = full >> 1;
    r = s ? ((a - b) & (full - 1)) : ((a + b) & (full - 1));
    c = s ? (a >= b) : (((a + b) >> w) != 0);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    exact = s ? sa - sb : sa + sb;
    v = (exact < -half) || (exact >= half);
  endfunction

  // Carry entering bit position sh of the chained operation.
  function automatic bit exp_cin(input int sh, input longint a, input longint b, input bit s);
    longint m;
    m = (longint'(1) << sh) - 1;
    if (s) return (a & m) >= (b & m);
    return (((a & m) + (b & m)) >> sh) != 0;
  endfunction

  task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int hold, input bit junk);
    longint r; bit c, v, ci; int n;
    ref_model(16, a, b, s, r, c, v);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_val("in_ready_wait", in_ready, 1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      ci = exp_cin(4 * i, a, b, s);
      out_ready = 1'($urandom);
      check_val("fa_A", fa_A, (a >> (4 * i)) & 16'hF);
      check_val("fa_B", fa_B, ((b >> (4 * i)) & 16'hF) ^ ((s ^ ci) ? 4'hF : 4'h0));
      check_val("fa_Cin", fa_Cin, ci);
      check_val("run_out_valid", out_valid, 0);
      check_val("run_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check_val("latency_out_valid", out_valid, 1);
    for (int k = 0; k < hold; k++) begin
      if (junk) begin in_valid = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom); end
      check_val("hold_result", result, r);
      check_val("hold_carry", carry_out, c);
      check_val("hold_ovf", overflow, v);
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      check_val("hold_fa_A", fa_A, 0);
      @(posedge clk); #1;
    end
    check_val("result", result, r);
    check_val("carry_out", carry_out, c);
    check_val("overflow", overflow, v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_out_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
  endtask

  task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic s);
    longint r; bit c, v;
    ref_model(4, a, b, s, r, c, v);
    check_val("n1_in_ready", in_ready1, 1);
    op_a1 = a; op_b1 = b; sub1 = s; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check_val("n1_fa_A", fa_A1, a);
    check_val("n1_fa_B", fa_B1, b);
    check_val("n1_fa_Cin", fa_Cin1, s);
    check_val("n1_run_out_valid", out_valid1, 0);
    @(posedge clk); #1;
    check_val("n1_latency", out_valid1, 1);
    check_val("n1_result", result1, r);
    check_val("n1_carry", carry_out1, c);
    check_val("n1_ovf", overflow1, v);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check_val("n1_post_out_valid", out_valid1, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    in_valid1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0; op_a1 = '0; op_b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_carry", carry_out, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_fa", {fa_A, fa_B, fa_Cin}, 0);
    rst = 1'b0;

    do_op4(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
    do_op4(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
    do_op4(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    do_op4(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op4(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    // Backpressure with a competing request; it is taken after one IDLE cycle.
    do_op4(16'hABCD, 16'h1357, 1'b1, 3, 1'b1);
    do_op4(16'h4242, 16'h1111, 1'b0, 0, 1'b0);

    // Reset mid-RUN after the second nibble.
    op_a = 16'hFFFF; op_b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_result", result, 0);
    check_val("abort_fa", {fa_A, fa_B, fa_Cin}, 0);
    do_op4(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    for (int t = 0; t < 30; t++)
      do_op4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);

    do_op1(4'hA, 4'h3, 1'b1);
    for (int t = 0; t < 16; t++)
      do_op1(4'($urandom), 4'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
